// File: rtl/data_sram_responder.sv
// Purpose : slave end of the CPU data-memory port; word storage with byte-lane stores.
// Latency : LATENCY edges from acceptance to the data_ok cycle (LATENCY==1 answers on the next cycle).
// Backpressure: one request in flight; addr_ok is low from acceptance until the IDLE cycle after RESP.
//
// Ports:
//   clk_i      clock, all state on the rising edge
//   rst_i      asynchronous active-low reset
//   req_i      request valid          wr_i    1 = store, 0 = load
//   size_i     0 byte, 1 half, 2 word, 3 reserved
//   addr_i     byte address           wdata_i lane-replicated store data
//   addr_ok_o  request accepted when req_i & addr_ok_o
//   data_ok_o  one-cycle response strobe
//   rdata_o    aligned read word (0 for stores and errors), valid with data_ok_o
//   err_o      size/alignment error, valid with data_ok_o
module data_sram_responder #(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2          // legal range 1..15
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        wr_i,
   input  logic [1:0]  size_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        addr_ok_o,
   output logic        data_ok_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;

   // captured request
   logic                wr_q;
   logic [1:0]          size_q;
   logic [ADDR_W+1:0]   addr_q;
   logic [31:0]         wdata_q;

   // registered response outputs
   logic                data_ok_q;
   logic                err_q;
   logic [31:0]         rdata_q;

   logic [31:0]         mem [2**ADDR_W];

   logic                accept;
   logic                enter_resp;

   // operation seen on the edge that enters RESP
   logic                op_wr;
   logic [1:0]          op_size;
   logic [ADDR_W+1:0]   op_addr;
   logic [31:0]         op_wdata;
   logic                op_err;
   logic [3:0]          op_be;
   logic [ADDR_W-1:0]   op_idx;

   // upper address bits alias away
   logic                unused_addr_hi;
   assign unused_addr_hi = ^addr_i[31:ADDR_W+2];

   assign addr_ok_o = (state_q == IDLE) && rst_i;
   assign accept    = req_i && addr_ok_o;

   // -------------------------------------------------------------------
   // next-state
   // -------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d   = LAT_M1;
               // a single-cycle latency skips WAIT entirely
               state_d = (LATENCY == 1) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign enter_resp = (state_d == RESP) && (state_q != RESP);

   // -------------------------------------------------------------------
   // Operation select: with LATENCY==1 the edge that enters RESP is the
   // acceptance edge itself, so the live inputs are used; otherwise the
   // captured copy is used.
   // -------------------------------------------------------------------
   always_comb begin
      if (state_q == IDLE) begin
         op_wr    = wr_i;
         op_size  = size_i;
         op_addr  = addr_i[ADDR_W+1:0];
         op_wdata = wdata_i;
      end else begin
         op_wr    = wr_q;
         op_size  = size_q;
         op_addr  = addr_q;
         op_wdata = wdata_q;
      end
   end

   assign op_idx = op_addr[ADDR_W+1:2];

   always_comb begin
      op_err = 1'b0;
      op_be  = 4'b0000;
      case (op_size)
         2'd0: op_be = 4'b0001 << op_addr[1:0];
         2'd1: begin
            op_err = op_addr[0];
            op_be  = op_addr[1] ? 4'b1100 : 4'b0011;
         end
         2'd2: begin
            op_err = |op_addr[1:0];
            op_be  = 4'b1111;
         end
         default: op_err = 1'b1;
      endcase
   end

   // -------------------------------------------------------------------
   // FSM, capture and registered response
   // -------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         wr_q      <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= '0;
         wdata_q   <= 32'd0;
         data_ok_q <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            wr_q    <= wr_i;
            size_q  <= size_i;
            addr_q  <= addr_i[ADDR_W+1:0];
            wdata_q <= wdata_i;
         end
         // RESP lasts exactly one cycle, so the response registers are
         // loaded on entry and cleared on every other edge.
         if (enter_resp) begin
            data_ok_q <= 1'b1;
            err_q     <= op_err;
            rdata_q   <= (op_err || op_wr) ? 32'd0 : mem[op_idx];
         end else begin
            data_ok_q <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
         end
      end
   end

   // Storage is never reset; stores commit only on the RESP-entry edge,
   // which cannot occur while reset is asserted.
   always_ff @(posedge clk_i) begin
      if (enter_resp && op_wr && !op_err) begin
         for (int b = 0; b < 4; b++) begin
            if (op_be[b]) begin
               mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
            end
         end
      end
   end

   assign data_ok_o = data_ok_q;
   assign err_o     = err_q;
   assign rdata_o   = rdata_q;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave end of the CPU data-memory port: answers the load/store requests the pipeline's memory stage issues over the SRAM-like handshake (req/addr_ok/data_ok).
- Contains word-organised storage with byte-lane writes and a programmable response latency, so the bench and SoC can exercise memory-stage stalls.
- Sits between the CPU core's data interface and the SoC memory map, in place of an ideal single-cycle RAM.
- Holds one request in flight at a time.

Parameters:
- ADDR_W, 12, word-index width; storage depth is 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to data_ok; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- req  in  1  request valid from CPU.
- wr  in  1  1 = store, 0 = load.
- size  in  2  access size: 0 = byte, 1 = halfword, 2 = word, 3 = reserved.
- addr  in  32  byte address.
- wdata  in  32  store data, already lane-replicated by the CPU.
- addr_ok  out  1  request accepted this cycle when req & addr_ok.
- data_ok  out  1  one-cycle response strobe.
- rdata  out  32  full aligned read word; valid only while data_ok=1.
- err  out  1  alignment/size error flag; valid only while data_ok=1.

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- addr_ok is combinational: 1 iff state==IDLE and rst==1.
- IDLE:
  - On an edge with req & addr_ok, capture wr, size, addr, wdata.
  - Load the counter with LATENCY-1.
  - Next state is RESP if LATENCY==1, otherwise WAIT.
- WAIT:
  - Counter decrements every cycle.
  - Once the counter reaches 0, the next edge goes to RESP.
  - req, addr and wdata are ignored while in WAIT.
- Latency: with acceptance at edge E0, data_ok is high for exactly the cycle following edge E_LATENCY.
- RESP:
  - data_ok=1 and err and rdata are driven from registers.
  - The next edge returns to IDLE.
  - addr_ok=0, so a new request cannot be accepted during RESP.
  - Maximum throughput is one request per LATENCY+1 cycles.
- Storage commit:
  - Stores commit on the edge that enters RESP.
  - Loads sample storage on that same edge.
  - A load issued after a store to the same word returns the new data.
- Address mapping:
  - Word index = addr[ADDR_W+1:2].
  - Upper address bits are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
- Store byte-enable:
  - size 0: lane addr[1:0].
  - size 1: lanes {addr[1],1} and {addr[1],0}.
  - size 2: all 4 lanes.
  - Each enabled lane takes the corresponding byte of wdata; other lanes are unchanged.
- Error conditions: size==3, (size==1 & addr[0]), or (size==2 & addr[1:0]!=0).
  - No store commits.
  - rdata=0 and err=1 in RESP.
  - The response is still given, so the CPU never hangs.
- Load rdata: full unshifted word; lane extraction and sign extension belong to the CPU.
- Store rdata: 0 with data_ok=1.
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, data_ok=0, rdata=0, err=0, captured request cleared.
  - An in-flight request is abandoned, and a store not yet committed never commits.
  - Storage contents are not cleared.
- Release from reset: addr_ok may rise in the first cycle after rst goes to 1.
- Outside RESP, data_ok=0, err=0 and rdata=0.

Test Plan:
- Word store then load, LATENCY=2: store addr 0x00000010, wdata 0xDEADBEEF, size 2. Then load addr 0x10.
  - Store: data_ok high 2 cycles after acceptance.
  - Load: data_ok with rdata=0xDEADBEEF, err=0.
  - addr_ok low for 3 cycles after each acceptance.
- Byte and halfword lanes: store word 0x11223344 @0x20, then byte wdata 0xAAAAAAAA size 0 @0x21, then halfword 0xBBBBBBBB size 1 @0x22.
  - Load @0x20 returns 0xBBBBAA44.
- Misalignment: store size 2 @0x24 (word 0x55667788 already there) with addr=0x26; then size 3 @0x24.
  - Both responses: err=1, rdata=0.
  - Load @0x24 still returns 0x55667788.
- Aliasing and LATENCY=1 (ADDR_W=12): store 0xCAFEF00D @0x00004004, then load @0x00000004.
  - Returns 0xCAFEF00D.
  - Each response arrives one cycle after acceptance.
  - Back-to-back requests accepted every 2 cycles.
- Reset mid-operation: accept store 0x12345678 @0x30 (old value 0), pull rst=0 during WAIT, release, then load @0x30.
  - data_ok never pulses for the aborted store.
  - Load returns 0x00000000.
  - data_ok, err and rdata read 0 during reset.
- Request held during WAIT/RESP: keep req=1 with changing addr for the whole transaction.
  - Only the captured address is serviced.
  - The next acceptance occurs in the first IDLE cycle and uses that cycle's addr.
